// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and frame-state encoding for the transmitter and receiver
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int CLKS_PER_BIT_DEF = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} frame_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered full/empty and a combinational head read
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_nxt;
  logic we;
  assign we = wr && (!full || rd);
  assign count_nxt = count + {{AW{1'b0}}, we} - {{AW{1'b0}}, rd};
  assign dout = mem[rd_ptr];
  // storage write; a write while full is only taken when the head leaves the same cycle
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally at the power-of-two depth; flags are registered from the next count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= count_nxt == (AW+1)'(DEPTH);
      empty <= count_nxt == '0;
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 serial transmitter sending queued bytes back-to-back
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data_i,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       signal_o
);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  frame_state_e state;
  logic [DW-1:0] div;
  logic [2:0] bit_idx;
  logic [7:0] shift, head;
  logic [CW-1:0] count;
  logic pop, last;
  assign last = div == DIV_LAST;
  assign pop = !empty && (state == IDLE || (state == STOP && last));
  assign overflow = wr_en && !pop && count == CW'(FIFO_DEPTH);
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_W)) u_fifo (
    .clk(CLK), .rst(RST), .wr(wr_en), .rd(pop), .din(data_i),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // frame sequencer: the line value is registered alongside each state change so it never glitches
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      div      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      signal_o <= 1'b1;
      busy     <= 1'b0;
    end else begin
      div <= (state == IDLE || last) ? '0 : div + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state    <= START;
          shift    <= head;
          signal_o <= 1'b0;
          busy     <= 1'b1;
        end
        START: if (last) begin
          state    <= DATA;
          bit_idx  <= '0;
          signal_o <= shift[0];
        end
        DATA: if (last) begin
          shift    <= shift >> 1;
          bit_idx  <= bit_idx + 1'b1;
          signal_o <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
          state    <= (bit_idx == 3'd7) ? STOP : DATA;
        end
        STOP: if (last) begin
          state    <= pop ? START : IDLE;
          shift    <= head;
          signal_o <= !pop;
          busy     <= pop;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of timing, FIFO flags, reset abort and a loopback receiver
module tb_uart_tx_buffered;
  localparam int CPB = 16;
  logic CLK = 0, RST = 1, wr_en = 0;
  logic [7:0] data_i = 0;
  logic full, empty, overflow, busy, signal_o;
  int cyc = 0, checks = 0, failures = 0, ferr = 0, t = 0, bad = 0;
  logic [7:0] rxq[$], expq[$], b;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .data_i(data_i), .wr_en(wr_en), .full(full),
    .empty(empty), .overflow(overflow), .busy(busy), .signal_o(signal_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // mid-bit sampling receiver standing in for the loopback partner
  initial forever begin
    logic [7:0] rb;
    @(negedge CLK);
    if (signal_o === 1'b0) begin
      repeat (CPB/2) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        rb[i] = signal_o;
      end
      repeat (CPB) @(negedge CLK);
      if (signal_o !== 1'b1) ferr++;
      rxq.push_back(rb);
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(string tag);
    check({tag, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) check(tag, rxq[i], expq[i]);
    rxq.delete();
  endtask

  task automatic goto(int c);
    do @(negedge CLK); while (cyc < c);
  endtask

  task automatic push(logic [7:0] v);
    @(posedge CLK); #1 wr_en = 1; data_i = v;
  endtask

  task automatic idle();
    @(posedge CLK); #1 wr_en = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1; wr_en = 0;
    @(posedge CLK); #1 RST = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_signal", signal_o, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    @(posedge CLK); #1 RST = 0;

    // single frame 0xAA with exact latency and busy window
    b = 8'hAA;
    push(b); t = cyc;
    goto(t);
    check("t1_empty_n", empty, 1);
    check("t1_line_n", signal_o, 1);
    idle();
    goto(t + 1);
    check("t1_empty_n1", empty, 0);
    check("t1_line_n1", signal_o, 1);
    goto(t + 2);
    check("t1_start_edge", signal_o, 0);
    check("t1_busy_start", busy, 1);
    goto(t + 10);
    check("t1_start_mid", signal_o, 0);
    for (int i = 0; i < 8; i++) begin
      goto(t + 26 + 16*i);
      check("t1_bit", signal_o, b[i]);
    end
    goto(t + 154);
    check("t1_stop", signal_o, 1);
    goto(t + 161);
    check("t1_busy_last", busy, 1);
    goto(t + 162);
    check("t1_busy_fall", busy, 0);
    check("t1_empty_end", empty, 1);
    goto(t + 180);
    expq = '{8'hAA};
    check_rx("t1_rx");

    // back-to-back frames with no idle gap
    push(8'h55); t = cyc;
    push(8'hA5);
    idle();
    goto(t + 161);
    check("t2_stop_last", signal_o, 1);
    goto(t + 162);
    check("t2_next_start", signal_o, 0);
    check("t2_busy_held", busy, 1);
    goto(t + 340);
    expq = '{8'h55, 8'hA5};
    check_rx("t2_rx");

    // fill past capacity: tenth byte dropped
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(8'(i));
      if (i == 0) t = cyc;
      goto(cyc);
      if (i == 8) begin
        check("t3_full_before", full, 0);
        check("t3_ovf_before", overflow, 0);
      end
      if (i == 9) begin
        check("t3_full", full, 1);
        check("t3_ovf_pulse", overflow, 1);
      end
    end
    idle();
    goto(t + 10);
    check("t3_ovf_clear", overflow, 0);
    check("t3_full_held", full, 1);
    goto(t + 1462);
    expq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_rx("t3_rx");
    check("t3_empty_end", empty, 1);

    // write while full on the cycle of a stop-bit pop
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(8'h10 + 8'(i));
      if (i == 0) t = cyc;
    end
    idle();
    goto(t + 160);
    check("t4_full_pre", full, 1);
    push(8'hEE);
    goto(cyc);
    check("t4_ovf_pop", overflow, 0);
    check("t4_full_pop", full, 1);
    idle();
    goto(t + 162);
    check("t4_full_after", full, 1);
    check("t4_ovf_after", overflow, 0);
    goto(t + 1622);
    expq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hEE};
    check_rx("t4_rx");

    // reset mid-frame aborts and discards the queue
    do_reset();
    push(8'h3C); t = cyc;
    push(8'h01);
    push(8'h02);
    idle();
    goto(t + 73);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    check("t5_busy_pre", busy, 1);
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK);
    check("t5_line", signal_o, 1);
    check("t5_busy", busy, 0);
    check("t5_empty", empty, 1);
    check("t5_full", full, 0);
    bad = 0;
    repeat (400) begin
      @(negedge CLK);
      if (signal_o !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_quiet", bad, 0);
    rxq.delete();
    ferr = 0;

    // loopback byte stream
    do_reset();
    push(8'h00); t = cyc;
    push(8'hFF);
    push(8'hAA);
    push(8'h5A);
    idle();
    goto(t + 662);
    expq = '{8'h00, 8'hFF, 8'hAA, 8'h5A};
    check_rx("t6_rx");
    check("t6_framing", ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
